// File: rtl/shift_ex_stage.sv
// RV32I shift execute stage: SLL/SRL computed locally, SRA through the shared sra unit,
// result registered behind a 2-entry skid buffer so in_ready is a pure register output.
`timescale 1ns/1ps

// Combinational 32-bit arithmetic right shift; amounts of 32 or more saturate to sign fill.
module sra (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic signed [31:0] a_s;
  logic        [31:0] shifted;

  assign a_s     = a;
  // Kept in its own assignment so the signed operand is not demoted by a mixed-sign context.
  assign shifted = a_s >>> b[4:0];
  assign y       = (|b[31:5]) ? {32{a[31]}} : shifted;
endmodule

module shift_ex_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_shamt_src,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd
);
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  logic [4:0]      shamt;
  logic            unused_shamt_hi;
  logic [XLEN-1:0] sra_y;
  logic [XLEN-1:0] new_result;

  logic            main_valid;
  logic [XLEN-1:0] main_result;
  logic [RD_W-1:0] main_rd;
  logic            skid_valid;
  logic [XLEN-1:0] skid_result;
  logic [RD_W-1:0] skid_rd;

  logic            accept;
  logic            main_free;

  assign shamt           = in_shamt_src[4:0];
  assign unused_shamt_hi = ^in_shamt_src[XLEN-1:5];

  sra u_sra (
    .a (in_rs1),
    .b ({{(XLEN-5){1'b0}}, shamt}),
    .y (sra_y)
  );

  // NOTE: default assigned first so every path through the case drives new_result (no latch).
  always_comb begin
    new_result = in_rs1;
    case (op_e'(in_op))
      OP_SLL:  new_result = in_rs1 << shamt;
      OP_SRL:  new_result = in_rs1 >> shamt;
      OP_SRA:  new_result = sra_y;
      default: new_result = in_rs1;
    endcase
  end

  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign out_result = main_result;
  assign out_rd     = main_rd;

  assign accept    = in_valid & in_ready & ~flush;
  assign main_free = ~main_valid | out_ready;

  // Flush wins over every other update; skid always drains into main before new ops enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_result <= '0;
      main_rd     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid  <= 1'b1;
        main_result <= skid_result;
        main_rd     <= skid_rd;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        main_valid  <= 1'b1;
        main_result <= new_result;
        main_rd     <= in_rd;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload is qualified by skid_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!main_free && accept) begin
      skid_result <= new_result;
      skid_rd     <= in_rd;
    end
  end
endmodule

// File: tb/tb_shift_ex_stage.sv
// Scoreboard bench for shift_ex_stage: directed corner cases, then a long random mix
// checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_shift_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_shamt_src;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  shift_ex_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs1       (in_rs1),
    .in_shamt_src (in_shamt_src),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Shifts expressed as multiply/divide by a power of two; SRA via complement symmetry.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] src);
    longint unsigned p;
    longint unsigned av;
    p  = 64'd1 << (src % 32);
    av = {32'd0, a};
    case (op)
      2'd0:    return 32'(av * p);
      2'd1:    return 32'(av / p);
      2'd2:    return a[31] ? ~32'({32'd0, ~a} / p) : 32'(av / p);
      default: return a;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds an op until accepted; the expected result goes into the scoreboard at acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] src,
                      input logic [4:0] rd);
    bit   done = 0;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_shamt_src = src; in_rd = rd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        e.res = model(op, a, src);
        e.rd  = rd;
        sb.push_back(e);
        done = 1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rd=%0d never accepted", rd);
    end
  endtask

  // Monitor: pops on every output handshake and checks output stability while stalled.
  logic        hold_prev = 1'b0;
  logic [31:0] hold_res;
  logic [4:0]  hold_rd;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", out_result, hold_res);
        check("hold_rd", 32'(out_rd), 32'(hold_rd));
      end
      hold_prev = out_valid & ~out_ready & ~flush;
      hold_res  = out_result;
      hold_rd   = out_rd;
      if (flush) begin
        sb.delete();
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result=%h rd=%0d with empty scoreboard",
                   out_result, out_rd);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("rd", 32'(out_rd), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'd0; in_rs1 = '0; in_shamt_src = '0; in_rd = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    step();
    rst = 1'b0;
    step();

    // SRA by 31 with sign bit set, one-cycle latency
    out_ready = 1'b1;
    send(2'd2, 32'h8000_0000, 32'h0000_001F, 5'd8);
    check("sra31_valid", 32'(out_valid), 32'd1);
    check("sra31_result", out_result, 32'hFFFF_FFFF);

    // Upper shamt bits ignored
    send(2'd1, 32'hF000_000F, 32'hFFFF_FFE4, 5'd9);
    check("srl_mask_result", out_result, 32'h0F00_0000);
    send(2'd0, 32'hF000_000F, 32'hFFFF_FFE4, 5'd10);
    check("sll_mask_result", out_result, 32'h0000_00F0);
    send(2'd3, 32'h1234_5678, 32'h0000_0003, 5'd11);
    check("pass_result", out_result, 32'h1234_5678);
    step();

    // Back-pressure: A in main, B in skid, C held upstream until the stall releases
    out_ready = 1'b0;
    send(2'd0, 32'h0000_0001, 32'd1, 5'd1);
    send(2'd1, 32'h8000_0000, 32'd2, 5'd2);
    fork
      send(2'd2, 32'h8000_0000, 32'd3, 5'd3);
      begin
        step(); step(); step();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_main_rd", 32'(out_rd), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_second_rd", 32'(out_rd), 32'd2);
        step();
        check("bp_third_rd", 32'(out_rd), 32'd3);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
      end
    join

    // Flush with main, skid and an incoming op all live
    out_ready = 1'b0;
    send(2'd0, 32'hAAAA_AAAA, 32'd4, 5'd4);
    send(2'd1, 32'h5555_5555, 32'd5, 5'd5);
    in_valid = 1'b1; in_op = 2'd2; in_rs1 = 32'hDEAD_BEEF; in_shamt_src = 32'd6; in_rd = 5'd6;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_output", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-cycle while a result is held
    out_ready = 1'b0;
    send(2'd0, 32'h0000_00FF, 32'd8, 5'd7);
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_result", out_result, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    check("postrst_in_ready", 32'(in_ready), 32'd1);

    // Random mix with stalls and occasional flushes
    for (int c = 0; c < 10000; c++) begin
      exp_t e;
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 63) == 0);
      in_valid     = ($urandom_range(0, 2) != 0);
      in_op        = 2'($urandom);
      in_rs1       = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | $urandom) : $urandom;
      in_shamt_src = $urandom;
      in_rd        = 5'($urandom);
      @(negedge clk);
      if (in_valid && in_ready && !flush) begin
        e.res = model(in_op, in_rs1, in_shamt_src);
        e.rd  = in_rd;
        sb.push_back(e);
      end
      step();
    end

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
